readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_readout_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sequencer.sv
// Frame sequencer for a linear image sensor: reset/transfer pulses, pixel clock burst with
// round-robin ADC starts, then sample-reset / integrate / sample-signal phases.
module readout_sequencer #(
  parameter int N_PIXELS    = 128,
  parameter int N_ADC       = 4,
  parameter int EXTRA_CLKS  = 5,
  parameter int CLK_HALF    = 15,
  parameter int T_SHORT     = 5,
  parameter int T_HOLD      = 2,
  parameter int T_SETUP     = 5,
  parameter int T_SHR_DELAY = 60,
  parameter int T_SHS_DELAY = 675,
  localparam int PIX_W      = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1,
  localparam int ADC_W      = (N_ADC > 1) ? $clog2(N_ADC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             running,
  input  logic             start,
  input  logic [31:0]      integ_cycles,
  output logic             INTG,
  output logic             IRST,
  output logic             SHS,
  output logic             SHR,
  output logic             STI,
  output logic             CLK,
  output logic [N_ADC-1:0] start_adc,
  output logic [PIX_W-1:0] pixel_index,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  typedef enum logic [3:0] {
    IDLE, RST_PH, SETUP, READ, TAIL, SHR_PH, INTG_PH, SETTLE, SHS_PH, END
  } state_t;

  localparam logic [31:0] RST_LEN  = 32'(T_SHORT + T_HOLD);
  localparam logic [31:0] SHORT_L  = 32'(T_SHORT);
  localparam logic [31:0] SETUP_L  = 32'(T_SETUP);
  localparam logic [31:0] TAIL_L   = 32'(T_SHR_DELAY - CLK_HALF);
  localparam logic [31:0] SETTLE_L = 32'(T_SHS_DELAY);
  localparam logic [31:0] HALF_L   = 32'(CLK_HALF);
  localparam logic [31:0] PERIOD_L = 32'(2 * CLK_HALF);
  localparam logic [31:0] NPE_L    = 32'(N_PIXELS + EXTRA_CLKS);
  localparam logic [31:0] NPIX_L   = 32'(N_PIXELS);
  localparam logic [ADC_W-1:0] ADC_LAST = ADC_W'(N_ADC - 1);

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        k_q, k_d;
  logic [31:0]        h_q, h_d;
  logic [31:0]        integ_q, integ_d;
  logic [31:0]        intg_len;
  logic [ADC_W-1:0]   adc_sel_q, adc_sel_d;
  logic [N_ADC-1:0]   start_adc_q, start_adc_d;
  logic [PIX_W-1:0]   pixel_index_q, pixel_index_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               sti_q, sti_d, irst_q, irst_d, clk_q, clk_d;
  logic               shr_q, shr_d, intg_q, intg_d, shs_q, shs_d;
  logic               busy_q, busy_d, frame_done_q, frame_done_d;

  assign intg_len = (integ_q == '0) ? 32'd1 : integ_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    k_d           = k_q;
    h_d           = h_q;
    integ_d       = integ_q;
    adc_sel_d     = adc_sel_q;
    pixel_index_d = pixel_index_q;
    start_adc_d   = '0;
    frame_count_d = frame_count_q;

    if (state_q == RST_PH && cnt_q == '0) begin
      integ_d = integ_cycles;
    end

    // ADC start trails the pixel's CLK rising edge by one cycle
    if (state_q == READ && h_q == '0 && k_q < NPIX_L) begin
      start_adc_d[adc_sel_q] = 1'b1;
      pixel_index_d          = k_q[PIX_W-1:0];
      adc_sel_d              = (adc_sel_q == ADC_LAST) ? '0 : adc_sel_q + ADC_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (running || start) state_d = RST_PH;
      end
      RST_PH: if (cnt_q == RST_LEN - 32'd1) begin
        state_d = SETUP;
        cnt_d   = '0;
      end
      SETUP: if (cnt_q == SETUP_L - 32'd1) begin
        state_d   = READ;
        cnt_d     = '0;
        k_d       = '0;
        h_d       = '0;
        adc_sel_d = '0;
      end
      READ: begin
        cnt_d = '0;
        if (k_q == NPE_L - 32'd1 && h_q == HALF_L - 32'd1) begin
          state_d = TAIL;
        end else if (h_q == PERIOD_L - 32'd1) begin
          h_d = '0;
          k_d = k_q + 32'd1;
        end else begin
          h_d = h_q + 32'd1;
        end
      end
      TAIL: if (cnt_q == TAIL_L - 32'd1) begin
        state_d = SHR_PH;
        cnt_d   = '0;
      end
      SHR_PH: if (cnt_q == SHORT_L - 32'd1) begin
        state_d = INTG_PH;
        cnt_d   = '0;
      end
      INTG_PH: if (cnt_q == intg_len - 32'd1) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: if (cnt_q == SETTLE_L - 32'd1) begin
        state_d = SHS_PH;
        cnt_d   = '0;
      end
      SHS_PH: if (cnt_q == SHORT_L - 32'd1) begin
        state_d = END;
        cnt_d   = '0;
      end
      END: if (cnt_q == SHORT_L) begin
        state_d = running ? RST_PH : IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Sensor lines are registered images of the state being entered
    sti_d        = (state_d == RST_PH) && (cnt_d < SHORT_L);
    irst_d       = (state_d == RST_PH);
    clk_d        = (state_d == READ) && (h_d < HALF_L);
    shr_d        = (state_d == SHR_PH);
    intg_d       = (state_d == INTG_PH);
    shs_d        = (state_d == SHS_PH);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == END) && (cnt_d == SHORT_L);
    if (frame_done_d) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      k_q           <= '0;
      h_q           <= '0;
      integ_q       <= '0;
      adc_sel_q     <= '0;
      start_adc_q   <= '0;
      pixel_index_q <= '0;
      frame_count_q <= '0;
      sti_q         <= 1'b0;
      irst_q        <= 1'b0;
      clk_q         <= 1'b0;
      shr_q         <= 1'b0;
      intg_q        <= 1'b0;
      shs_q         <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      h_q           <= h_d;
      integ_q       <= integ_d;
      adc_sel_q     <= adc_sel_d;
      start_adc_q   <= start_adc_d;
      pixel_index_q <= pixel_index_d;
      frame_count_q <= frame_count_d;
      sti_q         <= sti_d;
      irst_q        <= irst_d;
      clk_q         <= clk_d;
      shr_q         <= shr_d;
      intg_q        <= intg_d;
      shs_q         <= shs_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign STI         = sti_q;
  assign IRST        = irst_q;
  assign CLK         = clk_q;
  assign SHR         = shr_q;
  assign INTG        = intg_q;
  assign SHS         = shs_q;
  assign start_adc   = start_adc_q;
  assign pixel_index = pixel_index_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench: a closed-form timing model pushes every expected output edge/pulse,
// a negedge monitor pops and compares each event the sequencer actually produces.
module tb_readout_sequencer;

  localparam int NP = 8, NA = 4, EX = 2, CH = 2;
  localparam int TS = 3, TH = 1, TU = 3, TR = 6, TD = 10;
  localparam int T0  = TS + TH + TU;
  localparam int NPE = NP + EX;
  localparam int TL  = T0 + (NPE - 1) * 2 * CH;
  localparam int TI  = TL + TR + TS;

  typedef struct packed {
    logic [7:0]  k;
    logic [31:0] c;
    logic [23:0] v;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset, running, start;
  logic [31:0] integ_cycles;
  logic        INTG, IRST, SHS, SHR, STI, sclk;
  logic [NA-1:0] start_adc;
  logic [2:0]  pixel_index;
  logic        busy, frame_done;
  logic [15:0] frame_count;

  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   exp_frames = 0;
  ev_t  sb[$];
  logic [5:0] prev_lv = '0;

  readout_sequencer #(
    .N_PIXELS(NP), .N_ADC(NA), .EXTRA_CLKS(EX), .CLK_HALF(CH), .T_SHORT(TS),
    .T_HOLD(TH), .T_SETUP(TU), .T_SHR_DELAY(TR), .T_SHS_DELAY(TD)
  ) dut (
    .clk(clk), .reset(reset), .running(running), .start(start),
    .integ_cycles(integ_cycles), .INTG(INTG), .IRST(IRST), .SHS(SHS), .SHR(SHR),
    .STI(STI), .CLK(sclk), .start_adc(start_adc), .pixel_index(pixel_index),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string ev_name(input int k);
    case (k)
      0: return "ev_STI";
      1: return "ev_IRST";
      2: return "ev_CLK";
      3: return "ev_SHR";
      4: return "ev_INTG";
      5: return "ev_SHS";
      6: return "ev_adc";
      default: return "ev_done";
    endcase
  endfunction

  // Expected line levels at frame time t: {SHS, INTG, SHR, CLK, IRST, STI}
  function automatic logic [5:0] lv_at(input int t, input int ie);
    logic [5:0] lv;
    int ts;
    ts = TI + ie + TD;
    lv[0] = (t < TS);
    lv[1] = (t < TS + TH);
    lv[2] = (t >= T0) && (t < TL + CH) && (((t - T0) % (2 * CH)) < CH);
    lv[3] = (t >= TL + TR) && (t < TL + TR + TS);
    lv[4] = (t >= TI) && (t < TI + ie);
    lv[5] = (t >= ts) && (t < ts + TS);
    return lv;
  endfunction

  function automatic int adc_at(input int t);
    int p;
    if (t < T0 + 1 || ((t - T0 - 1) % (2 * CH)) != 0) return 0;
    p = (t - T0 - 1) / (2 * CH);
    if (p >= NP) return 0;
    return (p << 16) | (1 << (p % NA));
  endfunction

  // Queue all events of a frame whose t=0 is cycle s; cut>=0 means reset lands at t=cut.
  task automatic push_frame(input int s, input int icfg, input int cut);
    int ie, te, last, a;
    logic [5:0] lv, pv;
    ie = (icfg == 0) ? 1 : icfg;
    te = TI + ie + TD + 2 * TS;
    last = (cut >= 0) ? cut : te;
    pv = '0;
    for (int t = 0; t <= last; t++) begin
      if (cut >= 0 && t == cut) begin
        lv = '0;
        a  = 0;
      end else begin
        lv = lv_at(t, ie);
        a  = adc_at(t);
      end
      for (int k = 0; k < 6; k++)
        if (lv[k] != pv[k]) sb.push_back(ev_t'{8'(k), 32'(s + t), 24'(lv[k])});
      if (a != 0) sb.push_back(ev_t'{8'd6, 32'(s + t), 24'(a)});
      if (cut < 0 && t == te) begin
        exp_frames++;
        sb.push_back(ev_t'{8'd7, 32'(s + t), 24'(exp_frames & 16'hFFFF)});
      end
      pv = lv;
    end
  endtask

  task automatic obs_event(input int k, input int c, input int v);
    ev_t o;
    o = ev_t'{8'(k), 32'(c), 24'(v)};
    if (sb.size() == 0) check_eq(ev_name(k), o, '1);
    else check_eq(ev_name(k), o, sb.pop_front());
  endtask

  always @(negedge clk) begin : mon
    logic [5:0] cur;
    cur = {SHS, INTG, SHR, sclk, IRST, STI};
    for (int k = 0; k < 6; k++)
      if (cur[k] != prev_lv[k]) obs_event(k, cyc, int'(cur[k]));
    if (start_adc != '0) obs_event(6, cyc, (int'(pixel_index) << 16) | int'(start_adc));
    if (frame_done) obs_event(7, cyc, int'(frame_count));
    prev_lv <= cur;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {INTG, IRST, SHS, SHR, STI, sclk, start_adc, pixel_index, busy, frame_done, frame_count};
  endfunction

  initial begin
    int s;
    reset = 1'b1;
    running = 1'b0;
    start = 1'b0;
    integ_cycles = 32'd0;
    step(3);
    check_eq("rst_outs", all_outs(), '0);
    reset = 1'b0;
    step(6);
    check_eq("quiet_after_rst", all_outs(), '0);

    // three back-to-back frames, running dropped during the third
    integ_cycles = 32'd20;
    s = cyc + 1;
    push_frame(s, 20, -1);
    push_frame(s + 89, 20, -1);
    push_frame(s + 178, 20, -1);
    running = 1'b1;
    wait_until(s + 188);
    running = 1'b0;
    wait_until(s + 268);
    check_eq("cont_idle_busy", busy, 1'b0);
    check_eq("cont_fcount", frame_count, 16'd3);

    // single frame with a start pulse that must be ignored mid-frame
    s = cyc + 1;
    push_frame(s, 20, -1);
    pulse_start();
    check_eq("single_busy_t0", busy, 1'b1);
    wait_until(s + 30);
    pulse_start();
    wait_until(s + 88);
    check_eq("single_busy_tE", busy, 1'b1);
    step(1);
    check_eq("single_idle", busy, 1'b0);
    step(3);

    // zero integration behaves as one cycle
    integ_cycles = 32'd0;
    s = cyc + 1;
    push_frame(s, 0, -1);
    pulse_start();
    wait_until(s + 70);
    check_eq("zero_idle", busy, 1'b0);
    step(3);

    // integ_cycles change mid-frame only affects the following frame
    integ_cycles = 32'd20;
    s = cyc + 1;
    push_frame(s, 20, -1);
    push_frame(s + 89, 5, -1);
    running = 1'b1;
    wait_until(s + 30);
    integ_cycles = 32'd5;
    wait_until(s + 99);
    running = 1'b0;
    wait_until(s + 89 + 74);
    check_eq("chg_idle", busy, 1'b0);
    step(3);

    // asynchronous reset in the middle of the pixel burst
    integ_cycles = 32'd20;
    s = cyc + 1;
    push_frame(s, 20, 20);
    pulse_start();
    wait_until(s + 20);
    reset = 1'b1;
    exp_frames = 0;
    step(1);
    check_eq("midrst_outs", all_outs(), '0);
    reset = 1'b0;
    step(10);
    check_eq("midrst_quiet", all_outs(), '0);
    s = cyc + 1;
    push_frame(s, 20, -1);
    pulse_start();
    wait_until(s + 90);
    check_eq("midrst_idle", busy, 1'b0);
    check_eq("midrst_fcount", frame_count, 16'd1);

    check_eq("sb_drained", 64'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
